// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character LCD controller:
// FSM state encodings, LCD command bytes, cursor limits and the init ROM.
package lcd_pkg;

    // Top-level sequencing states
    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT,
        ST_IDLE,
        ST_CHAR,
        ST_WRAP,
        ST_DONE
    } state_t;

    // Phases of a single LCD bus write
    typedef enum logic [2:0] {
        B_IDLE,
        B_SETUP,
        B_EPULSE,
        B_HOLD,
        B_WAIT
    } bus_state_t;

    // HD44780 command bytes
    localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] CMD_ENTRY    = 8'h06;  // increment, no shift
    localparam logic [7:0] CMD_CLR      = 8'h01;
    localparam logic [7:0] CMD_HOME     = 8'h02;
    localparam logic [7:0] CMD_LINE1    = 8'h80;
    localparam logic [7:0] CMD_LINE2    = 8'hC0;

    // Byte treated as a newline when that feature is built in
    localparam logic [7:0] CHAR_NL = 8'h0A;

    // Cursor positions on a 16x2 panel, col 0..31
    localparam logic [4:0] LAST_COL_L1 = 5'd15;
    localparam logic [4:0] LINE2_COL   = 5'd16;
    localparam logic [4:0] LAST_COL_L2 = 5'd31;

    // Init ROM: four commands, the last one clears the display
    localparam logic [1:0] INIT_LAST = 2'd3;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = CMD_FUNC_SET;
            2'd1:    init_cmd = CMD_DISP_ON;
            2'd2:    init_cmd = CMD_ENTRY;
            default: init_cmd = CMD_CLR;
        endcase
    endfunction

    // Clear and home need the long post-write delay
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] db);
        is_long_cmd = !rs && (db == CMD_CLR || db == CMD_HOME);
    endfunction

endpackage

// File: rtl/lcd_if.sv
// Print handshake between the decoder (master) and the LCD controller (slave).
interface lcd_if;
    logic       strt;
    logic [7:0] lcd_data;
    logic       lcd_done;
    logic       busy;

    modport master (output strt, output lcd_data, input lcd_done, input busy);
    modport slave  (input strt, input lcd_data, output lcd_done, output busy);
endinterface

// File: rtl/lcd_bus_cycle.sv
// One complete HD44780 write: SETUP -> EPULSE -> HOLD -> WAIT.
// rs/db are captured on go and held on the pins until the next go.
// cyc_done is high in the last WAIT cycle, so a new go in that same cycle
// chains writes back to back with no idle gap.
module lcd_bus_cycle
    import lcd_pkg::*;
#(
    parameter int T_SETUP = 2,
    parameter int T_EPW   = 13,
    parameter int T_CMD   = 1100,
    parameter int T_CLR   = 44000,
    parameter int CNT_W   = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
    input  logic       rs,
    input  logic [7:0] db,
    input  logic       long_wait,
    output logic       cyc_done,
    output logic       lcd_rs,
    output logic       lcd_e,
    output logic [7:0] lcd_db
);

    bus_state_t       state, next_state;
    logic [CNT_W-1:0] cnt;
    logic             long_q;
    logic             last;

    // Phase length decode and next-phase selection
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        last       = 1'b0;
        next_state = state;
        case (state)
            B_SETUP:  last = (cnt == CNT_W'(T_SETUP - 1));
            B_EPULSE: last = (cnt == CNT_W'(T_EPW - 1));
            B_HOLD:   last = 1'b1;
            B_WAIT:   last = (cnt == (long_q ? CNT_W'(T_CLR - 1) : CNT_W'(T_CMD - 1)));
            default:  last = 1'b0;
        endcase
        if (last) begin
            case (state)
                B_SETUP:  next_state = B_EPULSE;
                B_EPULSE: next_state = B_HOLD;
                B_HOLD:   next_state = B_WAIT;
                default:  next_state = B_IDLE;
            endcase
        end
        if (go) next_state = B_SETUP;
    end

    // Phase register and per-phase cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n) begin
            state <= B_IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= (go || last || state == B_IDLE) ? '0 : cnt + 1'b1;
        end
    end

    // Capture the byte and its wait class at the start of each write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcd_rs <= 1'b0;
            lcd_db <= '0;
            long_q <= 1'b0;
        end else if (go) begin
            lcd_rs <= rs;
            lcd_db <= db;
            long_q <= long_wait;
        end
    end

    // E decoded straight from the phase register: glitch-free, drops at once on reset
    assign lcd_e    = (state == B_EPULSE);
    assign cyc_done = (state == B_WAIT) && last;

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 16x2 character LCD controller, responder side of the PRNT handshake.
// Runs the 8-bit init sequence after power-up, then writes each requested
// byte with automatic line wrap and pulses lcd_done once it is on the glass.
// Build option: LCD_NEWLINE_EN makes byte 0x0A move to the other line
// instead of being printed.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int T_PWRUP = 405000,
    parameter int T_SETUP = 2,
    parameter int T_EPW   = 13,
    parameter int T_CMD   = 1100,
    parameter int T_CLR   = 44000,
    parameter int CNT_W   = 20
) (
    input  logic       clk,
    input  logic       sys_rst_n,
    lcd_if.slave       hs,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_db
);

    state_t           state, next_state;
    logic [CNT_W-1:0] pwr_cnt;
    logic [1:0]       init_idx, init_idx_nxt;
    logic [4:0]       col, col_nxt;
    logic             pending;
    logic [7:0]       pend_byte;
    logic             strt_r, strt_q;
    logic [7:0]       data_r;
    logic             req;
    logic             go, go_rs;
    logic [7:0]       go_db;
    logic             long_wait;
    logic             start_char;
    logic [7:0]       start_byte;
    logic             cyc_done;

    assign req = strt_r & ~strt_q;

    // Register strt/lcd_data and keep the previous strt for edge detection
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            strt_r <= 1'b0;
            strt_q <= 1'b0;
            data_r <= '0;
        end else begin
            strt_r <= hs.strt;
            strt_q <= strt_r;
            data_r <= hs.lcd_data;
        end
    end

    // Next state, bus write requests and cursor updates
    always_comb begin
        next_state   = state;
        init_idx_nxt = init_idx;
        col_nxt      = col;
        go           = 1'b0;
        go_rs        = 1'b0;
        go_db        = 8'h00;
        start_char   = 1'b0;
        start_byte   = pending ? pend_byte : data_r;

        case (state)
            ST_PWRUP: begin
                if (pwr_cnt == CNT_W'(T_PWRUP - 1)) begin
                    go           = 1'b1;
                    go_db        = init_cmd(2'd0);
                    init_idx_nxt = 2'd0;
                    next_state   = ST_INIT;
                end
            end
            ST_INIT: begin
                if (cyc_done) begin
                    if (init_idx == INIT_LAST) begin
                        // Display cleared: cursor home; a request queued during
                        // init starts right away so busy never drops in between
                        col_nxt = '0;
                        if (pending || req) start_char = 1'b1;
                        else                next_state = ST_IDLE;
                    end else begin
                        init_idx_nxt = init_idx + 2'd1;
                        go           = 1'b1;
                        go_db        = init_cmd(init_idx_nxt);
                    end
                end
            end
            ST_IDLE: begin
                if (pending || req) start_char = 1'b1;
            end
            ST_CHAR: begin
                if (cyc_done) begin
                    if (col == LAST_COL_L1) begin
                        go         = 1'b1;
                        go_db      = CMD_LINE2;
                        col_nxt    = LINE2_COL;
                        next_state = ST_WRAP;
                    end else if (col == LAST_COL_L2) begin
                        go         = 1'b1;
                        go_db      = CMD_LINE1;
                        col_nxt    = '0;
                        next_state = ST_WRAP;
                    end else begin
                        col_nxt    = col + 5'd1;
                        next_state = ST_DONE;
                    end
                end
            end
            ST_WRAP: begin
                if (cyc_done) next_state = ST_DONE;
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_PWRUP;
        endcase

        if (start_char) begin
            go = 1'b1;
`ifdef LCD_NEWLINE_EN
            if (start_byte == CHAR_NL) begin
                go_rs      = 1'b0;
                go_db      = (col_nxt < LINE2_COL) ? CMD_LINE2 : CMD_LINE1;
                col_nxt    = (col_nxt < LINE2_COL) ? LINE2_COL : 5'd0;
                next_state = ST_WRAP;
            end else
`endif
            begin
                go_rs      = 1'b1;
                go_db      = start_byte;
                next_state = ST_CHAR;
            end
        end
    end

    // State, power-up timer, init index, cursor and the one-deep request queue
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= ST_PWRUP;
            pwr_cnt   <= '0;
            init_idx  <= '0;
            col       <= '0;
            pending   <= 1'b0;
            pend_byte <= '0;
        end else begin
            state    <= next_state;
            init_idx <= init_idx_nxt;
            col      <= col_nxt;
            pwr_cnt  <= (state == ST_PWRUP) ? pwr_cnt + 1'b1 : '0;
            if (start_char) begin
                pending <= 1'b0;
            end else if (req && state != ST_IDLE && !pending) begin
                pending   <= 1'b1;
                pend_byte <= data_r;
            end
        end
    end

    assign long_wait = is_long_cmd(go_rs, go_db);

    lcd_bus_cycle #(
        .T_SETUP (T_SETUP),
        .T_EPW   (T_EPW),
        .T_CMD   (T_CMD),
        .T_CLR   (T_CLR),
        .CNT_W   (CNT_W)
    ) u_bus (
        .clk       (clk),
        .rst_n     (sys_rst_n),
        .go        (go),
        .rs        (go_rs),
        .db        (go_db),
        .long_wait (long_wait),
        .cyc_done  (cyc_done),
        .lcd_rs    (lcd_rs),
        .lcd_e     (lcd_e),
        .lcd_db    (lcd_db)
    );

    assign lcd_rw      = 1'b0;
    assign hs.busy     = (state != ST_IDLE);
    assign hs.lcd_done = (state == ST_DONE);

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl with shortened timing.
// Expected LCD writes and lcd_done cycles are queued when a request is driven
// and popped by a monitor as E pulses and done pulses appear.
`timescale 1ns/1ps
module tb_lcd_ctrl;

    localparam int T_PWRUP = 20;
    localparam int T_SETUP = 1;
    localparam int T_EPW   = 2;
    localparam int T_CMD   = 4;
    localparam int T_CLR   = 8;
    // One ordinary write, from SETUP entry to the end of WAIT
    localparam int WR_CYC   = T_SETUP + T_EPW + 1 + T_CMD;
    // Init ends after power-up, three ordinary commands and one clear
    localparam int INIT_END = T_PWRUP + 3 * WR_CYC + T_SETUP + T_EPW + 1 + T_CLR;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_db;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;

    logic [8:0] exp_wr[$];    // {rs, db}
    int         exp_done[$];  // cycle at which lcd_done must be seen
    int         m_col = 0;
    int         n_e = 0;
    int         n_done = 0;

    lcd_if hs();

    lcd_ctrl #(
        .T_PWRUP (T_PWRUP),
        .T_SETUP (T_SETUP),
        .T_EPW   (T_EPW),
        .T_CMD   (T_CMD),
        .T_CLR   (T_CLR),
        .CNT_W   (20)
    ) dut (
        .clk       (clk),
        .sys_rst_n (rst_n),
        .hs        (hs),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_e     (lcd_e),
        .lcd_db    (lcd_db)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: expected writes and done time for a request seen at edge n
    task automatic expect_char(input logic [7:0] b, input int n);
        int t;
        t = n + 1 + WR_CYC;
`ifdef LCD_NEWLINE_EN
        if (b == 8'h0A) begin
            exp_wr.push_back({1'b0, (m_col < 16) ? 8'hC0 : 8'h80});
            m_col = (m_col < 16) ? 16 : 0;
        end else
`endif
        begin
            exp_wr.push_back({1'b1, b});
            if (m_col == 15) begin
                exp_wr.push_back({1'b0, 8'hC0});
                t += WR_CYC;
                m_col = 16;
            end else if (m_col == 31) begin
                exp_wr.push_back({1'b0, 8'h80});
                t += WR_CYC;
                m_col = 0;
            end else begin
                m_col++;
            end
        end
        exp_done.push_back(t);
    endtask

    // Monitor, sampled on the falling edge
    logic       e_prev = 1'b0;
    int         e_w = 0;
    logic [8:0] seen_wr = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            e_prev = 1'b0;
            e_w    = 0;
        end else begin
            if (lcd_e && !e_prev) begin
                n_e++;
                seen_wr = {lcd_rs, lcd_db};
                check("lcd_rw", lcd_rw, 0);
                check("wr_expected", exp_wr.size() != 0, 1);
                if (exp_wr.size() != 0) check("wr_rs_db", {lcd_rs, lcd_db}, exp_wr.pop_front());
            end
            if (lcd_e) e_w++;
            if (!lcd_e && e_prev) begin
                check("e_width", e_w, T_EPW);
                check("hold_rs_db", {lcd_rs, lcd_db}, seen_wr);
                e_w = 0;
            end
            if (hs.lcd_done) begin
                n_done++;
                check("done_expected", exp_done.size() != 0, 1);
                if (exp_done.size() != 0) check("done_cycle", cyc, exp_done.pop_front());
            end
            e_prev = lcd_e;
        end
    end

    task automatic wait_quiet(input int budget);
        int k;
        k = 0;
        while ((exp_done.size() != 0 || hs.busy) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("quiet_in_time", k < budget, 1);
        check("writes_drained", exp_wr.size(), 0);
    endtask

    task automatic send(input logic [7:0] b, input int hold);
        @(negedge clk);
        hs.lcd_data = b;
        hs.strt     = 1'b1;
        expect_char(b, cyc + 1);
        repeat (hold) @(negedge clk);
        hs.strt = 1'b0;
        repeat (2) @(negedge clk);
        wait_quiet(300);
    endtask

    // Reset, then follow the init sequence; optionally post 0x5A during init
    task automatic reset_and_init(input bit with_req);
        int   r;
        int   d0;
        logic saw_e;
        logic saw_low;
        rst_n       = 1'b0;
        hs.strt     = 1'b0;
        hs.lcd_data = 8'h00;
        exp_wr.delete();
        exp_done.delete();
        m_col = 0;
        repeat (3) @(negedge clk);
        check("rst_e", lcd_e, 0);
        check("rst_done", hs.lcd_done, 0);
        check("rst_db", lcd_db, 0);
        check("rst_rs", lcd_rs, 0);
        check("rst_busy", hs.busy, 1);
        rst_n = 1'b1;
        r     = cyc;
        d0    = n_done;
        exp_wr.push_back({1'b0, 8'h38});
        exp_wr.push_back({1'b0, 8'h0C});
        exp_wr.push_back({1'b0, 8'h06});
        exp_wr.push_back({1'b0, 8'h01});
        saw_e = 1'b0;
        repeat (T_PWRUP) begin
            @(negedge clk);
            saw_e |= lcd_e;
        end
        check("pwrup_no_e", saw_e, 0);
        @(negedge clk);
        check("init_first_e", lcd_e, 1);
        saw_low = 1'b0;
        while (cyc < r + INIT_END - 1) begin
            @(negedge clk);
            if (with_req && cyc == r + 30) begin
                hs.lcd_data = 8'h5A;
                hs.strt     = 1'b1;
            end
            if (with_req && cyc == r + 34) hs.strt = 1'b0;
            saw_low |= !hs.busy;
        end
        check("init_busy_high", saw_low, 0);
        // A queued byte starts as the clear's wait ends, like an edge one cycle earlier
        if (with_req) expect_char(8'h5A, r + INIT_END - 1);
        @(negedge clk);
        check("init_busy_fall", hs.busy, with_req);
        if (with_req) begin
            while (cyc < r + INIT_END + WR_CYC) begin
                @(negedge clk);
                saw_low |= !hs.busy;
            end
            check("pend_busy_high", saw_low, 0);
        end
        wait_quiet(300);
        check("init_done_count", n_done - d0, with_req ? 1 : 0);
    endtask

    initial begin
        int d0;
        int k;
        hs.strt     = 1'b0;
        hs.lcd_data = 8'h00;

        // Power-up and init
        reset_and_init(1'b0);

        // Two full lines from col 0: wraps after the 16th and 32nd chars
        for (int i = 0; i < 32; i++) send(8'h30 + i[7:0], 2);

        // Held strt gives exactly one write
        d0 = n_e;
        send(8'h41, 50);
        check("held_strt_one_e", n_e - d0, 1);

        // Move to col 3, then a newline byte
        send(8'h42, 2);
        send(8'h43, 2);
        d0 = n_e;
        send(8'h0A, 2);
        check("nl_one_e", n_e - d0, 1);

        // Reset in the middle of an E pulse
        @(negedge clk);
        hs.lcd_data = 8'h55;
        hs.strt     = 1'b1;
        expect_char(8'h55, cyc + 1);
        k = 0;
        while (!lcd_e && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("epulse_reached", lcd_e, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_e", lcd_e, 0);
        check("arst_done", hs.lcd_done, 0);
        check("arst_db", lcd_db, 0);
        check("arst_rs", lcd_rs, 0);
        check("arst_busy", hs.busy, 1);

        // Init repeats, with a request arriving during it
        reset_and_init(1'b1);

        send(8'h7E, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
